// File: rtl/ysyx_lsu_bus_resp.sv
// Fixed-latency scratchpad that answers LSU load/store requests after LATENCY cycles.
// Define YSYX_LSU_BUS_RESP_BOUNDS_EN to confine accesses to [BASE, BASE+DEPTH*4).
module ysyx_lsu_bus_resp #(
    parameter int              XLEN    = 32,
    parameter int              DEPTH   = 1024,
    parameter int              LATENCY = 2,
    parameter logic [XLEN-1:0] BASE    = XLEN'(32'h8000_0000)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            arvalid,
    input  logic [XLEN-1:0] araddr,
    input  logic [7:0]      rstrb,
    output logic            rvalid,
    output logic [XLEN-1:0] rdata,
    input  logic            awvalid,
    input  logic [XLEN-1:0] awaddr,
    input  logic            wvalid,
    input  logic [XLEN-1:0] wdata,
    input  logic [7:0]      wstrb,
    output logic            wready
);

    localparam int NB = XLEN / 8;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [NB-1:0]   strb_q, strb_d;
    logic            store_q, store_d;
    logic [XLEN-1:0] rd_word;
    logic            rd_ok, wr_ok;

    logic [XLEN-1:0] mem [DEPTH];

`ifdef YSYX_LSU_BUS_RESP_BOUNDS_EN
    localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH * 4);

    function automatic logic in_window(input logic [XLEN-1:0] a);
        logic [XLEN-1:0] off;
        off = a - BASE;
        return (a >= BASE) && ({1'b0, off} < SPAN);
    endfunction

    assign rd_ok = in_window(addr_d);
    assign wr_ok = in_window(addr_q);
`else
    assign rd_ok = 1'b1;
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        store_d = store_q;
        unique case (state_q)
            IDLE: begin
                // A complete store wins; a concurrent load simply stays pending.
                if (awvalid && wvalid) begin
                    addr_d  = awaddr;
                    wdata_d = wdata;
                    strb_d  = wstrb[NB-1:0];
                    store_d = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end else if (arvalid) begin
                    addr_d  = araddr;
                    strb_d  = rstrb[NB-1:0];
                    store_d = 1'b0;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load data is captured on the edge that enters RESP, so rdata is stable through the pulse.
    always_comb begin
        rdata_d = rdata_q;
        rd_word = rd_ok ? mem[addr_d[AW+1:2]] : '0;
        if (state_d == RESP && !store_d) begin
            for (int i = 0; i < NB; i++) begin
                rdata_d[8*i +: 8] = strb_d[i] ? rd_word[8*i +: 8] : 8'h00;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            strb_q  <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            strb_q  <= strb_d;
            store_q <= store_d;
        end
    end

    // The store commits at the end of RESP, so a reset during RESP leaves memory untouched.
    always_ff @(posedge clock) begin
        if (reset && state_q == RESP && store_q && wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (strb_q[i]) begin
                    mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign rvalid = (state_q == RESP) && !store_q;
    assign wready = (state_q == RESP) && store_q;
    assign rdata  = rdata_q;

    logic unused_bits;
    assign unused_bits = ^{rstrb, wstrb, addr_q};

endmodule
